branch_target_buffer: RTL

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 90 +++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Zero-cycle lookup from fetch, one training update per cycle from execute.
module branch_target_buffer #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic        HitF,
    output logic        PredTakenF,
    output logic [31:0] PredPCF,
    input  logic        UpdValidE,
    input  logic [31:0] UpdPCE,
    input  logic [31:0] UpdTargetE,
    input  logic        UpdTakenE,
    input  logic        UpdJumpE,
    input  logic        InvalidateAll
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_taken;
    logic             upd_hit;
    logic             upd_write;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_next;
    logic             unused_upd_lsbs;

    assign look_idx = PCF[IDX_W+1:2];
    assign look_tag = PCF[31:IDX_W+2];
    assign upd_idx  = UpdPCE[IDX_W+1:2];
    assign upd_tag  = UpdPCE[31:IDX_W+2];
    assign unused_upd_lsbs = ^UpdPCE[1:0];

    // Lookup reads registered state only, so a same-cycle update is seen next cycle.
    assign HitF       = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    assign PredTakenF = HitF && ctr_q[look_idx][1];
    assign PredPCF    = PredTakenF ? target_q[look_idx] : PCF + 32'd4;

    assign upd_taken = UpdTakenE || UpdJumpE;
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign ctr_cur   = ctr_q[upd_idx];
    // Target/tag are written on any taken update: allocation on a miss, retarget on a hit.
    assign upd_write = !reset && !InvalidateAll && UpdValidE && upd_taken;

    always_comb begin
        // NOTE: default assignment first so every path drives ctr_next and no latch is inferred.
        ctr_next = ctr_cur;
        if (!upd_hit) begin
            ctr_next = UpdJumpE ? 2'b11 : 2'b10;
        end else if (upd_taken) begin
            if (UpdJumpE || ctr_cur == 2'b11) ctr_next = 2'b11;
            else                              ctr_next = ctr_cur + 2'd1;
        end else if (ctr_cur != 2'b00) begin
            ctr_next = ctr_cur - 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
        end else if (InvalidateAll) begin
            valid_q <= '0;
        end else if (UpdValidE && (upd_hit || upd_taken)) begin
            valid_q[upd_idx] <= 1'b1;
            ctr_q[upd_idx]   <= ctr_next;
        end
    end

    // NOTE: tag/target storage is deliberately not reset; valid_q masks stale contents.
    always_ff @(posedge clk) begin
        if (upd_write) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= UpdTargetE;
        end
    end

endmodule
